// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: base opcodes, the canonical NOP and the
// decode-stage occupancy states.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // EMPTY: nothing held; FULL: held and offered to EX; HOLD: held, load-use blocked
  typedef enum logic [1:0] {
    EMPTY,
    FULL,
    HOLD
  } id_state_e;

endpackage

// File: rtl/id_src_use.sv
// Source-register usage decode, shared with the forwarding unit.
//   opcode_i   [6:0]  instruction opcode field
//   use_rs1_o         instruction reads rs1
//   use_rs2_o         instruction reads rs2
// U/J-type and unrecognised opcodes read no sources.
module id_src_use
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic       use_rs1_o,
  output logic       use_rs2_o
);

  always_comb begin
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    case (opcode_i)
      OPC_OP, OPC_BRANCH, OPC_STORE: begin
        use_rs1_o = 1'b1;
        use_rs2_o = 1'b1;
      end
      OPC_LOAD, OPC_JALR, OPC_OPIMM: begin
        use_rs1_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage sequencer: owns the IF/ID instruction register, handles
// fetch/execute handshakes, load-use bubbles, redirect flushes, and keeps a
// saturating count of stall cycles.
//   clk, rst      clock; synchronous active-high reset
//   if_valid/if_inst/if_pc/if_ready   fetch offer and acceptance
//   ex_ready      execute accepts an issue
//   ex_valid/ex_is_load/ex_rd         instruction currently in EX
//   ex_redirect   flush younger work
//   id_valid/id_inst/id_pc            issue to execute (id_inst feeds imm_gen)
//   id_stall      load-use hazard held ID this cycle
//   stall_cnt     saturating stall-cycle counter (not cleared by flush)
module id_stage_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W        = 64,
  parameter int unsigned STALL_CNT_W = 32,
  parameter logic [31:0] NOP_INST    = riscv_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  input  logic [31:0]            if_inst,
  input  logic [PC_W-1:0]        if_pc,
  output logic                   if_ready,
  input  logic                   ex_ready,
  input  logic                   ex_valid,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_redirect,
  output logic                   id_valid,
  output logic [31:0]            id_inst,
  output logic [PC_W-1:0]        id_pc,
  output logic                   id_stall,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  id_state_e              state_q, state_d;
  logic [31:0]            inst_q, inst_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic use_rs1, use_rs2;
  logic held, hazard, fire;

  id_src_use u_src_use (
    .opcode_i  (inst_q[6:0]),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2)
  );

  always_comb begin
    held   = (state_q != EMPTY);
    hazard = held && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
             ((use_rs1 && (inst_q[19:15] == ex_rd)) ||
              (use_rs2 && (inst_q[24:20] == ex_rd)));

    id_valid = held && !hazard && !ex_redirect;
    id_stall = hazard && !ex_redirect;
    fire     = id_valid && ex_ready;
    // Refill in the same cycle the held instruction leaves, so streaming has no bubbles
    if_ready = !ex_redirect && (!held || fire);

    state_d = state_q;
    inst_d  = inst_q;
    pc_d    = pc_q;

    if (ex_redirect) begin
      state_d = EMPTY;
      inst_d  = NOP_INST;
    end else if (if_valid && if_ready) begin
      state_d = FULL;
      inst_d  = if_inst;
      pc_d    = if_pc;
    end else if (fire) begin
      state_d = EMPTY;
      inst_d  = NOP_INST;
    end else if (hazard) begin
      state_d = HOLD;
    end else if (state_q == HOLD) begin
      state_d = FULL;
    end

    cnt_d = cnt_q;
    if (id_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign id_inst   = inst_q;
  assign id_pc     = pc_q;
  assign stall_cnt = cnt_q;

endmodule
